dmem_responder: RTL

- Tagged memory-side responder: the far end of the processor's data-memory bus.
- Accepts one command per cycle on Dmem_command/addr/size/data; grants each accepted command a nonzero 4-bit tag on mem2proc_response.
- Loads return a 64-bit doubleword on mem2proc_data/mem2proc_tag a fixed number of cycles later. Stores commit at accept.
- Used as the backing memory for the data-cache controller in simulation and on the synthesizable test harness.

---
 rtl/mem_bus_pkg.sv | 33 +++
 rtl/dmem_resp_pipe.sv | 42 ++++
 rtl/dmem_responder.sv | 107 ++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared data-memory bus encodings, tag width and the load-return pipeline stage type.
package mem_bus_pkg;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } mem_size_e;

    localparam int unsigned MEM_TAG_W = 4;

    typedef struct packed {
        logic                 valid;
        logic [MEM_TAG_W-1:0] tag;
        logic [63:0]          data;
    } pipe_stage_t;

    // Byte-enable pattern for an access starting at lane 0.
    function automatic logic [7:0] size_mask(input mem_size_e size);
        case (size)
            BYTE:    return 8'h01;
            HALF:    return 8'h03;
            WORD:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/dmem_resp_pipe.sv
// Fixed-latency shift pipeline carrying load snapshots; data fields only move with a valid
// entry so the final stage keeps the last returned doubleword.
module dmem_resp_pipe
    import mem_bus_pkg::*;
#(
    parameter int unsigned LATENCY = 10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  pipe_stage_t i_stage,
    output pipe_stage_t o_stage
);

    pipe_stage_t r_stage [LATENCY];
    pipe_stage_t w_prev  [LATENCY];

    always_comb begin
        w_prev[0] = i_stage;
        for (int i = 1; i < int'(LATENCY); i++) begin
            w_prev[i] = r_stage[i-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_stage[i].valid <= w_prev[i].valid;
                r_stage[i].tag   <= w_prev[i].valid ? w_prev[i].tag : '0;
                if (w_prev[i].valid) begin
                    r_stage[i].data <= w_prev[i].data;
                end
            end
        end
    end

    assign o_stage = r_stage[LATENCY-1];

endmodule

// File: rtl/dmem_responder.sv
// Tagged data-memory responder: stores commit at accept, loads return after a fixed latency.
// Optional random command refusal is enabled by defining MEM_RAND_STALL_EN.
module dmem_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned MEM_LATENCY_CYCLES = 10,
    parameter int unsigned MEM_DEPTH_WORDS    = 8192,
    parameter logic [7:0]  LFSR_SEED          = 8'hA5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           Dmem_command,
    input  logic [15:0]          Dmem_addr,
    input  logic [1:0]           Dmem_size,
    input  logic [63:0]          Dmem_data,
    output logic [MEM_TAG_W-1:0] mem2proc_response,
    output logic [63:0]          mem2proc_data,
    output logic [MEM_TAG_W-1:0] mem2proc_tag
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH_WORDS);

    logic [63:0]          r_mem [MEM_DEPTH_WORDS];
    logic [MEM_TAG_W-1:0] r_tag;

    logic                 w_stall;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_store;
    logic [IDX_W-1:0]     w_index;
    logic [2:0]           w_lane;
    logic [7:0]           w_be;
    logic [63:0]          w_wdata;
    pipe_stage_t          w_pipe_in;
    pipe_stage_t          w_pipe_out;

`ifdef MEM_RAND_STALL_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    logic w_unused_seed;

    assign w_unused_seed = ^LFSR_SEED;
    assign w_stall       = 1'b0;
`endif

    assign w_accept = ((Dmem_command == BUS_LOAD) || (Dmem_command == BUS_STORE))
                      && reset && !w_stall;
    assign w_load   = w_accept && (Dmem_command == BUS_LOAD);
    assign w_store  = w_accept && (Dmem_command == BUS_STORE);

    assign mem2proc_response = w_accept ? r_tag : '0;

    assign w_index = Dmem_addr[3 +: IDX_W];
    assign w_lane  = Dmem_addr[2:0];
    // Shifting left truncates bytes that would spill past lane 7.
    assign w_be    = size_mask(mem_size_e'(Dmem_size)) << w_lane;
    assign w_wdata = Dmem_data << {w_lane, 3'b000};

    always_ff @(posedge clock) begin
        if (w_store) begin
            for (int b = 0; b < 8; b++) begin
                if (w_be[b]) begin
                    r_mem[w_index][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tag <= MEM_TAG_W'(1);
        end else if (w_accept) begin
            r_tag <= (r_tag == '1) ? MEM_TAG_W'(1) : r_tag + MEM_TAG_W'(1);
        end
    end

    always_comb begin
        w_pipe_in       = '0;
        w_pipe_in.valid = w_load;
        w_pipe_in.tag   = r_tag;
        w_pipe_in.data  = r_mem[w_index];
    end

    dmem_resp_pipe #(
        .LATENCY (MEM_LATENCY_CYCLES)
    ) u_pipe (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_stage (w_pipe_in),
        .o_stage (w_pipe_out)
    );

    assign mem2proc_tag  = w_pipe_out.valid ? w_pipe_out.tag : '0;
    assign mem2proc_data = w_pipe_out.data;

endmodule
